// File: rtl/aes_loader_pkg.sv
// Shared widths and FSM encoding for the aes_128 word loader.
package aes_loader_pkg;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KEY  = 3'd1,
    S_PT   = 3'd2,
    S_WAIT = 3'd3,
    S_OUT  = 3'd4
  } state_e;
endpackage

// File: rtl/aes_word_serializer.sv
// Holds one ciphertext block and streams it out MSW first over valid/ready.
module aes_word_serializer
  import aes_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [BLOCK_W-1:0] blk,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_last,
  output logic               done
);
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] obuf_q, obuf_d;
  logic [1:0] ocnt_q, ocnt_d;
  logic       vld_q, vld_d;
  logic       xfer;

  assign xfer      = vld_q & out_ready;
  assign out_valid = vld_q;
  // Word 3 of the packed buffer is the most-significant word.
  assign out_data  = obuf_q[2'd3 - ocnt_q];
  assign out_last  = vld_q & (ocnt_q == 2'd3);
  assign done      = xfer & (ocnt_q == 2'd3);

  always_comb begin
    obuf_d = obuf_q;
    ocnt_d = ocnt_q;
    vld_d  = vld_q;
    if (load) begin
      obuf_d = blk;
      ocnt_d = 2'd0;
      vld_d  = 1'b1;
    end else if (xfer) begin
      ocnt_d = ocnt_q + 2'd1;
      if (ocnt_q == 2'd3) vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obuf_q <= '0;
      ocnt_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      obuf_q <= obuf_d;
      ocnt_q <= ocnt_d;
      vld_q  <= vld_d;
    end
  end
endmodule

// File: rtl/aes_word_loader.sv
// 32-bit stream front/back end for aes_128: loads key/plaintext words, waits
// out the core latency, then returns the ciphertext as four words.
module aes_word_loader
  import aes_loader_pkg::*;
#(
  parameter int AES_LATENCY = 21
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_key_keep,
  output logic [BLOCK_W-1:0] aes_state,
  output logic [BLOCK_W-1:0] aes_key,
  input  logic [BLOCK_W-1:0] aes_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_last,
  output logic               busy
);
  localparam int LCW = (AES_LATENCY > 1) ? $clog2(AES_LATENCY) : 1;

  state_e state_q, state_d;
  logic [1:0]     wcnt_q, wcnt_d;
  logic [LCW-1:0] lcnt_q, lcnt_d;
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] key_q, key_d, pt_q, pt_d;
  logic in_ready_q, in_ready_d;
  logic load_q, load_d;
  logic in_xfer, ser_done;

  assign in_xfer   = in_valid & in_ready_q;
  assign in_ready  = in_ready_q;
  assign aes_state = pt_q;
  assign aes_key   = key_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    lcnt_d  = lcnt_q;
    key_d   = key_q;
    pt_d    = pt_q;
    load_d  = 1'b0;
    case (state_q)
      S_IDLE: if (in_xfer) begin
        wcnt_d = 2'd1;
        if (in_key_keep) begin
          pt_d[3] = in_data;
          state_d = S_PT;
        end else begin
          key_d[3] = in_data;
          state_d  = S_KEY;
        end
      end
      S_KEY: if (in_xfer) begin
        key_d[2'd3 - wcnt_q] = in_data;
        wcnt_d = wcnt_q + 2'd1;
        if (wcnt_q == 2'd3) state_d = S_PT;
      end
      S_PT: if (in_xfer) begin
        pt_d[2'd3 - wcnt_q] = in_data;
        wcnt_d = wcnt_q + 2'd1;
        if (wcnt_q == 2'd3) begin
          state_d = S_WAIT;
          lcnt_d  = LCW'(AES_LATENCY - 1);
        end
      end
      // The capture strobe is registered so obuf samples aes_out one cycle
      // after the count expires, i.e. once the core result is settled.
      S_WAIT: if (lcnt_q == '0) begin
        state_d = S_OUT;
        load_d  = 1'b1;
      end else begin
        lcnt_d = lcnt_q - LCW'(1);
      end
      S_OUT: if (ser_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE) || (state_d == S_KEY) || (state_d == S_PT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      lcnt_q     <= '0;
      key_q      <= '0;
      pt_q       <= '0;
      in_ready_q <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      lcnt_q     <= lcnt_d;
      key_q      <= key_d;
      pt_q       <= pt_d;
      in_ready_q <= in_ready_d;
      load_q     <= load_d;
    end
  end

  aes_word_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_q),
    .blk       (aes_out),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (ser_done)
  );
endmodule
